// File: rtl/ip_water_lamp_pkg.sv
// Shared types and defaults for the running-light driver.
// Holds the mode and direction enums, board timing constants and the prescaler width helper.
package ip_water_lamp_pkg;

    typedef enum logic {
        MODE_ROTATE = 1'b0,
        MODE_BOUNCE = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int CLK_HZ              = 50_000_000;
    localparam int STEP_CYCLES_DEFAULT = 25_000_000;

    // A prescaler for a single-cycle step still needs one register bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/ip_water_lamp_if.sv
// LED bank bus: the driver owns the pins, the board side observes them.
interface ip_water_lamp_if #(
    parameter int LED_NUM = 4
);
    logic [LED_NUM-1:0] led;

    modport master (output led);
    modport slave  (input  led);
endinterface

// File: rtl/ip_water_lamp_tick.sv
// Free-running prescaler producing a one-cycle step pulse every STEP_CYCLES clocks.
// The pulse is high for the whole cycle in which the count sits at its terminal value.
module ip_water_lamp_tick
    import ip_water_lamp_pkg::*;
#(
    parameter int STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
    input  logic clk_50mhz,
    input  logic rst_n,
    output logic step_o
);

    localparam int              CNT_W    = cnt_width(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the values from before the edge regardless of block ordering.
    always_ff @(posedge clk_50mhz) begin
        if (rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign step_o = (count_q == CNT_LAST);

endmodule

// File: rtl/ip_water_lamp.sv
// Water-lamp driver: a one-hot LED pattern that rotates or bounces once per prescaler step.
// rst_n is an active-high synchronous reset despite its name; the output is fully registered.
module ip_water_lamp
    import ip_water_lamp_pkg::*;
#(
    parameter int LED_NUM     = 4,
    parameter int STEP_CYCLES = STEP_CYCLES_DEFAULT,
    parameter int MODE        = 0,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic               clk_50mhz,
    input  logic               rst_n,
    output logic [LED_NUM-1:0] led_out
);

    localparam bit                 BOUNCE    = (MODE == int'(MODE_BOUNCE));
    localparam logic [LED_NUM-1:0] POL_MASK  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [LED_NUM-1:0] PAT_RESET = LED_NUM'(1);

    logic               step;
    logic [LED_NUM-1:0] pattern_q;
    logic [LED_NUM-1:0] pattern_d;
    logic [LED_NUM-1:0] shifted;
    logic [LED_NUM-1:0] led_q;
    dir_e               dir_q;
    dir_e               dir_d;

    ip_water_lamp_tick #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_tick (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .step_o    (step)
    );

    // NOTE: every signal assigned here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        shifted   = '0;
        if (step) begin
            if (!$onehot(pattern_q)) begin
                pattern_d = PAT_RESET;
                dir_d     = DIR_UP;
            end else if (!BOUNCE) begin
                pattern_d = {pattern_q[LED_NUM-2:0], pattern_q[LED_NUM-1]};
            end else if (dir_q == DIR_UP) begin
                shifted   = pattern_q << 1;
                pattern_d = shifted;
                if (shifted[LED_NUM-1]) dir_d = DIR_DOWN;
            end else begin
                shifted   = pattern_q >> 1;
                pattern_d = shifted;
                if (shifted[0]) dir_d = DIR_UP;
            end
        end
    end

    // Polarity is folded in before the output flop so the pins see no logic after it.
    always_ff @(posedge clk_50mhz) begin
        if (rst_n) begin
            pattern_q <= PAT_RESET;
            dir_q     <= DIR_UP;
            led_q     <= PAT_RESET ^ POL_MASK;
        end else begin
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            led_q     <= pattern_d ^ POL_MASK;
        end
    end

    assign led_out = led_q;

endmodule

// File: tb/tb_ip_water_lamp.sv
// Self-checking bench: several parameterisations of ip_water_lamp run side by side,
// compared every edge against a position-based model of the rotate/bounce sequences.
module tb_ip_water_lamp;
    import ip_water_lamp_pkg::*;

    localparam int SCALED_STEP = STEP_CYCLES_DEFAULT / 1000;

    logic clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    logic rst_d = 1'b1;
    logic rst_e = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ip_water_lamp_if #(.LED_NUM(4)) bus_a ();
    ip_water_lamp_if #(.LED_NUM(4)) bus_b ();
    ip_water_lamp_if #(.LED_NUM(4)) bus_c ();
    ip_water_lamp_if #(.LED_NUM(4)) bus_d ();
    ip_water_lamp_if #(.LED_NUM(4)) bus_e ();

    ip_water_lamp #(.LED_NUM(4), .STEP_CYCLES(5), .MODE(0), .ACTIVE_LOW(0)) dut_a (
        .clk_50mhz (clk_50mhz), .rst_n (rst_a), .led_out (bus_a.led));
    ip_water_lamp #(.LED_NUM(4), .STEP_CYCLES(3), .MODE(1), .ACTIVE_LOW(0)) dut_b (
        .clk_50mhz (clk_50mhz), .rst_n (rst_b), .led_out (bus_b.led));
    ip_water_lamp #(.LED_NUM(4), .STEP_CYCLES(1), .MODE(0), .ACTIVE_LOW(1)) dut_c (
        .clk_50mhz (clk_50mhz), .rst_n (rst_c), .led_out (bus_c.led));
    ip_water_lamp #(.LED_NUM(4), .STEP_CYCLES(SCALED_STEP), .MODE(0), .ACTIVE_LOW(0)) dut_d (
        .clk_50mhz (clk_50mhz), .rst_n (rst_d), .led_out (bus_d.led));
    ip_water_lamp dut_e (
        .clk_50mhz (clk_50mhz), .rst_n (rst_e), .led_out (bus_e.led));

    // Lit LED position after a number of steps: rotate walks 0..3 cyclically,
    // bounce traces 0,1,2,3,2,1 with period 2*4-2.
    function automatic logic [3:0] model_led(input int steps, input bit bounce, input bit act_low);
        int p;
        int pos;
        if (!bounce) begin
            pos = steps % 4;
        end else begin
            p   = steps % 6;
            pos = (p < 4) ? p : 6 - p;
        end
        return 4'(1 << pos) ^ (act_low ? 4'hF : 4'h0);
    endfunction

    task automatic step_edge();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        rst_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_edge();
            total_cnt++;
            if (bus_a.led !== 4'b0001)
                $display("FAIL reset_hold edge %0d: got %b expected 0001", i, bus_a.led);
            else pass_cnt++;
        end
        rst_a = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step_edge();
            exp = (e < 5) ? 4'b0001 : 4'b0010;
            total_cnt++;
            if (bus_a.led !== exp)
                $display("FAIL reset_release edge %0d: got %b expected %b", e, bus_a.led, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_rotate_wrap();
        logic [3:0] exp;
        int hold;
        hold  = $urandom_range(1, 3);
        rst_a = 1'b1;
        repeat (hold) step_edge();
        rst_a = 1'b0;
        for (int e = 1; e <= 100; e++) begin
            step_edge();
            exp = model_led(e / 5, 1'b0, 1'b0);
            total_cnt++;
            if (bus_a.led !== exp)
                $display("FAIL rotate edge %0d: got %b expected %b", e, bus_a.led, exp);
            else pass_cnt++;
            total_cnt++;
            if (!$onehot(bus_a.led))
                $display("FAIL rotate_onehot edge %0d: got %b expected one-hot", e, bus_a.led);
            else pass_cnt++;
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp;
        int edges;
        edges = (8 + $urandom_range(0, 12)) * 3;
        rst_b = 1'b1;
        step_edge();
        rst_b = 1'b0;
        for (int e = 1; e <= edges; e++) begin
            step_edge();
            exp = model_led(e / 3, 1'b1, 1'b0);
            total_cnt++;
            if (bus_b.led !== exp)
                $display("FAIL bounce edge %0d: got %b expected %b", e, bus_b.led, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp;
        int k;
        int r;
        // Step counts congruent to 4 mod 6 leave LED2 lit on the way down.
        k     = 4 + 6 * $urandom_range(0, 2);
        r     = $urandom_range(0, 2);
        rst_b = 1'b1;
        step_edge();
        rst_b = 1'b0;
        repeat (k * 3 + r) step_edge();
        total_cnt++;
        if (bus_b.led !== 4'b0100)
            $display("FAIL mid_reset_setup: got %b expected 0100", bus_b.led);
        else pass_cnt++;
        rst_b = 1'b1;
        step_edge();
        total_cnt++;
        if (bus_b.led !== 4'b0001)
            $display("FAIL mid_reset_apply: got %b expected 0001", bus_b.led);
        else pass_cnt++;
        rst_b = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step_edge();
            exp = model_led(e / 3, 1'b1, 1'b0);
            total_cnt++;
            if (bus_b.led !== exp)
                $display("FAIL mid_reset_resume edge %0d: got %b expected %b", e, bus_b.led, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_polarity();
        logic [3:0] exp;
        int edges;
        edges = 4 + $urandom_range(0, 8);
        rst_c = 1'b1;
        repeat (2) step_edge();
        total_cnt++;
        if (bus_c.led !== 4'b1110)
            $display("FAIL polarity_reset: got %b expected 1110", bus_c.led);
        else pass_cnt++;
        rst_c = 1'b0;
        for (int e = 1; e <= edges; e++) begin
            step_edge();
            exp = model_led(e, 1'b0, 1'b1);
            total_cnt++;
            if (bus_c.led !== exp)
                $display("FAIL polarity edge %0d: got %b expected %b", e, bus_c.led, exp);
            else pass_cnt++;
        end
    endtask

    // Timing spot check at 1/1000 of the default step, plus the untouched default instance.
    task automatic test_default_timing();
        int mid;
        mid   = $urandom_range(1, SCALED_STEP - 2);
        rst_d = 1'b1;
        rst_e = 1'b1;
        step_edge();
        total_cnt++;
        if (bus_e.led !== 4'b0001)
            $display("FAIL default_reset: got %b expected 0001", bus_e.led);
        else pass_cnt++;
        rst_d = 1'b0;
        rst_e = 1'b0;
        for (int e = 1; e <= SCALED_STEP; e++) begin
            step_edge();
            if (e == mid || e == SCALED_STEP - 1) begin
                total_cnt++;
                if (bus_d.led !== 4'b0001)
                    $display("FAIL scaled_hold edge %0d: got %b expected 0001", e, bus_d.led);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (bus_d.led !== 4'b0010)
            $display("FAIL scaled_first_step: got %b expected 0010", bus_d.led);
        else pass_cnt++;
        total_cnt++;
        if (bus_e.led !== 4'b0001)
            $display("FAIL default_hold: got %b expected 0001", bus_e.led);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_rotate_wrap();
        test_bounce();
        test_mid_reset();
        test_polarity();
        test_default_timing();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
